// File: rtl/msg_play_pkg.sv
// Shared types and helpers for the secret-message playback controller.
package msg_play_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoading = 2'd1,
    StLoaded  = 2'd2,
    StPlaying = 2'd3
  } state_e;

  localparam int unsigned GLYPH_BIT      = 6;
  localparam int unsigned COLS_PER_GLYPH = 8;

  // Raw characters occupy the middle six rows of a single column.
  function automatic logic [7:0] RAW_COL(input logic [6:0] c);
    return {1'b0, c[5:0], 1'b0};
  endfunction

endpackage

// File: rtl/font_col_rom.sv
// Combinational glyph font: 6-bit glyph code plus column index to one 8-bit display column.
module font_col_rom (
  input  logic [5:0] char_code,
  input  logic [2:0] col,
  output logic [7:0] col_data
);

  logic [63:0] glyph;

  // Column 0 sits in the least significant byte.
  always_comb begin
    glyph = '0;
    unique case (char_code)
      6'd1:    glyph = 64'h003E_4549_5161_3E00; // '0'
      6'd2:    glyph = 64'h0000_0040_7F42_0000; // '1'
      6'd3:    glyph = 64'h0000_4649_4951_6200; // '2'
      6'd4:    glyph = 64'h0000_7C12_1112_7C00; // 'A'
      default: glyph = '0;
    endcase
  end

  assign col_data = glyph[{col, 3'b000} +: 8];

endmodule

// File: rtl/msg_play_ctrl.sv
// Message load/playback sequencer for the column display.
// Define MSG_LOOP_EN to make playback repeat until play_stop or rst.
module msg_play_ctrl
  import msg_play_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 16,
  parameter int unsigned DIV_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [6:0]                  load_char,
  input  logic                        load_last,
  input  logic                        play_start,
  input  logic                        play_stop,
  input  logic [DIV_W-1:0]            col_div,
  output logic                        col_valid,
  output logic [7:0]                  col_data,
  output logic                        play_done,
  output logic [$clog2(WORD_COUNT):0] msg_len,
  output logic [1:0]                  state_o
);

  localparam int unsigned IdxW = $clog2(WORD_COUNT);
  localparam int unsigned PtrW = IdxW + 1;

  state_e            state_q, state_d;
  logic [6:0]        mem_q [WORD_COUNT];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, len_q, len_d;
  logic [IdxW-1:0]   char_idx_q, char_idx_d;
  logic [2:0]        col_idx_q, col_idx_d;
  logic [DIV_W-1:0]  div_q, div_d, presc_q, presc_d;
  logic              col_valid_q, col_valid_d, done_q, done_d;
  logic [7:0]        col_data_q, col_data_d;

  logic              load_fire, new_msg, first_last, fill_last;
  logic              start_ok, tick, is_glyph, char_end, msg_end;
  logic [IdxW-1:0]   wr_addr;
  logic [6:0]        cur_char;
  logic [7:0]        rom_col;

  assign load_fire  = load_valid & load_ready;
  assign new_msg    = (state_q == StIdle) || (state_q == StLoaded);
  assign first_last = load_last || (WORD_COUNT == 1);
  assign fill_last  = load_last || (wr_ptr_q == PtrW'(WORD_COUNT - 1));
  assign wr_addr    = new_msg ? '0 : wr_ptr_q[IdxW-1:0];

  // A concurrent load takes precedence so an accepted handshake is never dropped.
  assign start_ok = (state_q == StLoaded) && play_start && !play_stop && (len_q != '0)
                    && !load_fire;
  assign tick     = (state_q == StPlaying) && !play_stop && (presc_q == '0);

  assign cur_char = mem_q[char_idx_q];
  assign is_glyph = cur_char[GLYPH_BIT];
  assign char_end = !is_glyph || (col_idx_q == 3'(COLS_PER_GLYPH - 1));
  assign msg_end  = char_end && ({1'b0, char_idx_q} == len_q - PtrW'(1));

  font_col_rom u_font (
    .char_code (cur_char[5:0]),
    .col       (col_idx_q),
    .col_data  (rom_col)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_fire) state_d = first_last ? StLoaded : StLoading;
      end
      StLoading: begin
        if (load_fire && fill_last) state_d = StLoaded;
      end
      StLoaded: begin
        if (load_fire)     state_d = first_last ? StLoaded : StLoading;
        else if (start_ok) state_d = StPlaying;
      end
      StPlaying: begin
        if (play_stop) begin
          state_d = StLoaded;
        end else if (tick && msg_end) begin
`ifdef MSG_LOOP_EN
          state_d = StPlaying;
`else
          state_d = StLoaded;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_ready  = (state_q != StPlaying);
    col_valid_d = tick;
    done_d      = tick && msg_end;
    col_data_d  = col_data_q;
    if (tick) col_data_d = is_glyph ? rom_col : RAW_COL(cur_char);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    div_d      = div_q;
    presc_d    = presc_q;
    char_idx_d = char_idx_q;
    col_idx_d  = col_idx_q;
    if (load_fire) begin
      if (new_msg) begin
        wr_ptr_d = PtrW'(1);
        len_d    = PtrW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        len_d    = len_q + PtrW'(1);
      end
    end
    if (start_ok) begin
      div_d      = col_div;
      presc_d    = '0;
      char_idx_d = '0;
      col_idx_d  = '0;
    end else if (tick) begin
      presc_d = div_q;
      if (char_end) begin
        col_idx_d  = '0;
        char_idx_d = msg_end ? '0 : char_idx_q + IdxW'(1);
      end else begin
        col_idx_d = col_idx_q + 3'd1;
      end
    end else if ((state_q == StPlaying) && !play_stop) begin
      presc_d = presc_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      len_q       <= '0;
      div_q       <= '0;
      presc_q     <= '0;
      char_idx_q  <= '0;
      col_idx_q   <= '0;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      len_q       <= len_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      char_idx_q  <= char_idx_d;
      col_idx_q   <= col_idx_d;
      col_valid_q <= col_valid_d;
      col_data_q  <= col_data_d;
      done_q      <= done_d;
    end
  end

  // Character storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load_fire) mem_q[wr_addr] <= load_char;
  end

  assign col_valid = col_valid_q;
  assign col_data  = col_data_q;
  assign play_done = done_q;
  assign msg_len   = len_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_msg_play_ctrl.sv
// Randomized self-checking bench for msg_play_ctrl against a message-level reference model.
module tb_msg_play_ctrl;

`ifdef MSG_LOOP_EN
  localparam bit Loop = 1'b1;
`else
  localparam bit Loop = 1'b0;
`endif
  localparam int SIdle = 0, SLoading = 1, SLoaded = 2, SPlaying = 3;

  logic       clk = 1'b0;
  logic       rst, load_valid, load_ready, load_last, play_start, play_stop;
  logic [6:0] load_char;
  logic [7:0] col_div, col_data;
  logic       col_valid, play_done;
  logic [4:0] msg_len;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  msg_play_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_char  (load_char),
    .load_last  (load_last),
    .play_start (play_start),
    .play_stop  (play_stop),
    .col_div    (col_div),
    .col_valid  (col_valid),
    .col_data   (col_data),
    .play_done  (play_done),
    .msg_len    (msg_len),
    .state_o    (state_o)
  );

  int         checks = 0;
  int         errors = 0;
  logic [6:0] model_msg[$];
  int         model_state = SIdle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] font(input logic [5:0] code, input int col);
    logic [7:0] g [8];
    case (code)
      6'd1:    g = '{8'h00, 8'h3E, 8'h61, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00};
      6'd2:    g = '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00, 8'h00};
      6'd3:    g = '{8'h00, 8'h62, 8'h51, 8'h49, 8'h49, 8'h46, 8'h00, 8'h00};
      6'd4:    g = '{8'h00, 8'h7C, 8'h12, 8'h11, 8'h12, 8'h7C, 8'h00, 8'h00};
      default: g = '{default: 8'h00};
    endcase
    return g[col];
  endfunction

  // Expected column stream for the whole stored message.
  task automatic build_cols(output logic [7:0] cols[$]);
    cols = {};
    foreach (model_msg[i]) begin
      if (model_msg[i][6]) begin
        for (int j = 0; j < 8; j++) cols.push_back(font(model_msg[i][5:0], j));
      end else begin
        cols.push_back(8'(model_msg[i][5:0]) * 8'd2);
      end
    end
  endtask

  task automatic load_one(input logic [6:0] c, input logic last);
    check_eq("load_ready", load_ready, 1);
    load_valid = 1'b1;
    load_char  = c;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (model_state == SIdle || model_state == SLoaded) model_msg.delete();
    model_msg.push_back(c);
    model_state = (last || model_msg.size() == 16) ? SLoaded : SLoading;
    check_eq("load_len", msg_len, model_msg.size());
    check_eq("load_state", state_o, model_state);
  endtask

  task automatic play_run(input int div, input int ncycles);
    logic [7:0] cols[$];
    int n, per, last_c;
    build_cols(cols);
    n      = cols.size();
    per    = div + 1;
    last_c = (n - 1) * per + 1;
    col_div    = 8'(div);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check_eq("start_state", state_o, SPlaying);
    check_eq("ready_playing", load_ready, 0);
    check_eq("start_no_col", col_valid, 0);
    for (int c = 1; c <= ncycles; c++) begin
      int k;
      bit on;
      step();
      k  = (c - 1) / per;
      on = ((c - 1) % per == 0) && (Loop || k < n);
      check_eq("col_valid", col_valid, on);
      if (on) begin
        check_eq("col_data", col_data, cols[k % n]);
        check_eq("play_done", play_done, (k % n) == n - 1);
      end else begin
        check_eq("play_done_idle", play_done, 0);
      end
      check_eq("play_state", state_o, (!Loop && c >= last_c) ? SLoaded : SPlaying);
    end
    model_state = (!Loop && ncycles >= last_c) ? SLoaded : SPlaying;
  endtask

  task automatic do_stop(input bit with_start);
    play_stop  = 1'b1;
    play_start = with_start;
    step();
    play_stop  = 1'b0;
    play_start = 1'b0;
    model_state = SLoaded;
    check_eq("stop_state", state_o, SLoaded);
    check_eq("stop_no_col", col_valid, 0);
    check_eq("stop_no_done", play_done, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("after_stop_col", col_valid, 0);
      check_eq("after_stop_done", play_done, 0);
      check_eq("after_stop_state", state_o, SLoaded);
    end
  endtask

  // Plays the whole message (two passes when looping, then stops).
  task automatic full_play(input int div);
    logic [7:0] cols[$];
    int n, per, ncyc;
    build_cols(cols);
    n    = cols.size();
    per  = div + 1;
    ncyc = (n - 1) * per + 1 + per;
    if (Loop) ncyc += n * per;
    play_run(div, ncyc);
    if (Loop) do_stop(1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_char  = '0;
    load_last  = 1'b0;
    play_start = 1'b0;
    play_stop  = 1'b0;
    col_div    = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_state", state_o, SIdle);
    check_eq("rst_len", msg_len, 0);
    check_eq("rst_col_valid", col_valid, 0);
    check_eq("rst_col_data", col_data, 0);
    check_eq("rst_done", play_done, 0);
    check_eq("rst_ready", load_ready, 1);

    // play_start in IDLE has no effect.
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check_eq("idle_start_state", state_o, SIdle);
    step();
    check_eq("idle_start_col", col_valid, 0);

    load_one(7'h05, 1'b0);
    load_one(7'h2A, 1'b1);
    full_play(0);

    load_one(7'h41, 1'b1);
    full_play(2);

    for (int i = 0; i < 16; i++) load_one(7'($urandom_range(0, 127)), 1'b0);
    check_eq("full_len", msg_len, 16);
    load_one(7'h13, 1'b0);
    load_one(7'h42, 1'b1);
    full_play(1);

    load_one(7'h41, 1'b0);
    load_one(7'h42, 1'b0);
    load_one(7'h43, 1'b1);
    play_run(1, 5);
    do_stop(1'b1);

    load_one(7'h05, 1'b0);
    load_one(7'h41, 1'b1);
    play_run(0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_msg.delete();
    model_state = SIdle;
    check_eq("midrst_state", state_o, SIdle);
    check_eq("midrst_len", msg_len, 0);
    check_eq("midrst_col", col_valid, 0);
    check_eq("midrst_done", play_done, 0);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check_eq("midrst_start_state", state_o, SIdle);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("midrst_start_col", col_valid, 0);
    end

    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        logic [6:0] c;
        if ($urandom_range(0, 1) == 1) c = 7'(64 + $urandom_range(0, 7));
        else                           c = 7'($urandom_range(0, 63));
        load_one(c, i == len - 1);
      end
      full_play($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
